// File: rtl/defense_fire_scheduler.sv
// Five-lane laser shot scheduler: captures fire-request edges, arbitrates round-robin,
// then steps the laser head up the screen once per frame followed by a cooldown.
module defense_fire_scheduler #(
  parameter int START_Y         = 375,
  parameter int TOP_Y           = 16,
  parameter int STEP            = 8,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       FrameTick,
  input  logic [4:0] FireReq,
  input  logic       HitAck,
  output logic [4:0] FireGrant,
  output logic       LaserActive,
  output logic [2:0] LaserLane,
  output logic [9:0] LaserX,
  output logic [9:0] LaserY,
  output logic       Busy
);

  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [9:0]    Y_START = 10'(START_Y);
  localparam logic [9:0]    Y_LIMIT = 10'(TOP_Y + STEP);
  localparam logic [9:0]    Y_STEP  = 10'(STEP);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_COOL} state_t;

  state_t        state, state_n;
  logic [4:0]    req_prev;
  logic [4:0]    pending, pending_n, pend_clr;
  logic [2:0]    last_lane, last_lane_n;
  logic [CW-1:0] cd_cnt, cd_cnt_n;
  logic [4:0]    grant_n;
  logic          active_n;
  logic [2:0]    lane_n;
  logic [9:0]    y_n;
  logic          found;
  logic [2:0]    pick;
  logic [2:0]    arb_idx;

  function automatic logic [9:0] lane_x(input logic [2:0] lane);
    case (lane)
      3'd1:    lane_x = 10'd336;
      3'd2:    lane_x = 10'd464;
      3'd3:    lane_x = 10'd592;
      3'd4:    lane_x = 10'd720;
      default: lane_x = 10'd208;
    endcase
  endfunction

  // Round-robin scan starting just after the last granted lane
  always_comb begin
    found   = 1'b0;
    pick    = last_lane;
    arb_idx = '0;
    for (int unsigned i = 1; i <= 5; i++) begin
      arb_idx = 3'((32'(last_lane) + i) % 5);
      if (!found && pending[arb_idx]) begin
        found = 1'b1;
        pick  = arb_idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    pend_clr    = '0;
    last_lane_n = last_lane;
    cd_cnt_n    = cd_cnt;
    grant_n     = '0;
    active_n    = LaserActive;
    lane_n      = LaserLane;
    y_n         = LaserY;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n     = 5'(5'b00001 << pick);
          pend_clr    = grant_n;
          last_lane_n = pick;
          lane_n      = pick;
          y_n         = Y_START;
          active_n    = 1'b1;
          state_n     = S_FLY;
        end
      end
      S_FLY: begin
        if (HitAck || (FrameTick && (LaserY < Y_LIMIT))) begin
          active_n = 1'b0;
          cd_cnt_n = CD_LOAD;
          state_n  = S_COOL;
        end else if (FrameTick) begin
          y_n = LaserY - Y_STEP;
        end
      end
      S_COOL: begin
        if (cd_cnt == '0) begin
          state_n = S_IDLE;
        end else if (FrameTick) begin
          cd_cnt_n = cd_cnt - CW'(1);
          if (cd_cnt == CW'(1)) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A new edge in the grant cycle re-arms the lane, so set is applied after clear
    pending_n = (pending & ~pend_clr) | (FireReq & ~req_prev);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      req_prev    <= '0;
      pending     <= '0;
      last_lane   <= 3'd4;
      cd_cnt      <= '0;
      FireGrant   <= '0;
      LaserActive <= 1'b0;
      LaserLane   <= '0;
      LaserX      <= 10'd208;
      LaserY      <= Y_START;
      Busy        <= 1'b0;
    end else begin
      state       <= state_n;
      req_prev    <= FireReq;
      pending     <= pending_n;
      last_lane   <= last_lane_n;
      cd_cnt      <= cd_cnt_n;
      FireGrant   <= grant_n;
      LaserActive <= active_n;
      LaserLane   <= lane_n;
      LaserX      <= lane_x(lane_n);
      LaserY      <= y_n;
      Busy        <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_defense_fire_scheduler.sv
// Bench for defense_fire_scheduler: vector table, directed corner sequences and
// randomized traffic checked against a frame-level behavioural model.
module tb_defense_fire_scheduler;

  localparam int START_Y  = 375;
  localparam int TOP_Y    = 16;
  localparam int STEP     = 8;
  localparam int COOLDOWN = 4;

  logic       Clock;
  logic       Resetn;
  logic       FrameTick;
  logic [4:0] FireReq;
  logic       HitAck;
  logic [4:0] FireGrant;
  logic       LaserActive;
  logic [2:0] LaserLane;
  logic [9:0] LaserX;
  logic [9:0] LaserY;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  defense_fire_scheduler #(
    .START_Y(START_Y),
    .TOP_Y(TOP_Y),
    .STEP(STEP),
    .COOLDOWN_FRAMES(COOLDOWN)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .FrameTick(FrameTick),
    .FireReq(FireReq),
    .HitAck(HitAck),
    .FireGrant(FireGrant),
    .LaserActive(LaserActive),
    .LaserLane(LaserLane),
    .LaserX(LaserX),
    .LaserY(LaserY),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural model: phase 0 = waiting, 1 = shot flying, 2 = cooling down
  int       m_phase;
  bit [4:0] m_pend;
  bit [4:0] m_prev;
  bit [4:0] m_grant;
  int       m_last;
  int       m_lane;
  int       m_y;
  int       m_cool;
  bit       m_active;

  function automatic void model_reset();
    m_phase  = 0;
    m_pend   = '0;
    m_prev   = '0;
    m_grant  = '0;
    m_last   = 4;
    m_lane   = 0;
    m_y      = START_Y;
    m_cool   = 0;
    m_active = 1'b0;
  endfunction

  function automatic void model_step(input bit t, input bit [4:0] r, input bit h);
    bit [4:0] rise;
    int l;
    rise    = r & ~m_prev;
    m_prev  = r;
    m_grant = '0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= 5; k++) begin
          l = (m_last + k) % 5;
          if (m_grant == 0 && m_pend[l]) begin
            m_grant[l] = 1'b1;
            m_pend[l]  = 1'b0;
            m_last     = l;
            m_lane     = l;
            m_y        = START_Y;
            m_active   = 1'b1;
            m_phase    = 1;
          end
        end
      end
      1: begin
        if (h || (t && m_y < TOP_Y + STEP)) begin
          m_active = 1'b0;
          m_cool   = COOLDOWN;
          m_phase  = 2;
        end else if (t) begin
          m_y = m_y - STEP;
        end
      end
      default: begin
        if (m_cool == 0) m_phase = 0;
        else if (t) begin
          m_cool = m_cool - 1;
          if (m_cool == 0) m_phase = 0;
        end
      end
    endcase
    m_pend = m_pend | rise;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".grant"},  32'(FireGrant),   32'(m_grant));
    chk({tag, ".active"}, 32'(LaserActive), 32'(m_active));
    chk({tag, ".lane"},   32'(LaserLane),   32'(m_lane));
    chk({tag, ".x"},      32'(LaserX),      32'(208 + 128 * m_lane));
    chk({tag, ".y"},      32'(LaserY),      32'(m_y));
    chk({tag, ".busy"},   32'(Busy),        32'(m_phase != 0));
  endtask

  // One clock: drive at negedge, model advances with the edge, compare at the next negedge
  task automatic cyc(input bit t, input logic [4:0] r, input bit h);
    FrameTick = t;
    FireReq   = r;
    HitAck    = h;
    @(posedge Clock);
    model_step(t, r, h);
    @(negedge Clock);
    compare_model("model");
  endtask

  task automatic do_reset(input logic [4:0] r);
    @(negedge Clock);
    Resetn    = 1'b0;
    FrameTick = 1'b0;
    HitAck    = 1'b0;
    FireReq   = r;
    model_reset();
    @(negedge Clock);
    compare_model("reset");
    Resetn = 1'b1;
  endtask

  task automatic fire(input logic [4:0] r);
    cyc(1'b0, r, 1'b0);
    cyc(1'b0, '0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, '0, 1'b0);
  endtask

  task automatic wait_grant(input string name, input logic [4:0] exp);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      cyc(1'b1, '0, 1'b0);
      if (FireGrant != '0) got = 1'b1;
    end
    chk(name, 32'(FireGrant), 32'(exp));
  endtask

  typedef struct {
    bit         tick;
    logic [4:0] req;
    bit         hit;
    logic [4:0] grant;
    bit         active;
    logic [2:0] lane;
    logic [9:0] y;
    bit         busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int extra;
    //            tick  req       hit   grant     act   lane  y        busy
    vecs[0] = '{1'b0, 5'b00100, 1'b0, 5'b00000, 1'b0, 3'd0, 10'd375, 1'b0};
    vecs[1] = '{1'b0, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2, 10'd375, 1'b1};
    vecs[2] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd2, 10'd367, 1'b1};
    vecs[3] = '{1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b1};
    vecs[4] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b1};
    vecs[5] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b1};
    vecs[6] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b1};
    vecs[7] = '{1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b0};
    vecs[8] = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 10'd367, 1'b0};

    Resetn = 1'b0; FrameTick = 1'b0; FireReq = '0; HitAck = 1'b0;
    model_reset();
    do_reset('0);
    chk("reset.x", 32'(LaserX), 32'd208);
    chk("reset.y", 32'(LaserY), 32'd375);

    foreach (vecs[i]) begin
      cyc(vecs[i].tick, vecs[i].req, vecs[i].hit);
      chk($sformatf("vec%0d.grant", i),  32'(FireGrant),   32'(vecs[i].grant));
      chk($sformatf("vec%0d.active", i), 32'(LaserActive), 32'(vecs[i].active));
      chk($sformatf("vec%0d.lane", i),   32'(LaserLane),   32'(vecs[i].lane));
      chk($sformatf("vec%0d.y", i),      32'(LaserY),      32'(vecs[i].y));
      chk($sformatf("vec%0d.busy", i),   32'(Busy),        32'(vecs[i].busy));
    end

    // Single full-length shot
    do_reset('0);
    cyc(1'b0, 5'b00100, 1'b0);
    chk("single.no_grant_yet", 32'(FireGrant), 32'd0);
    cyc(1'b0, '0, 1'b0);
    chk("single.grant", 32'(FireGrant), 32'b00100);
    chk("single.x", 32'(LaserX), 32'd464);
    chk("single.y0", 32'(LaserY), 32'd375);
    chk("single.active", 32'(LaserActive), 32'd1);
    cyc(1'b0, '0, 1'b0);
    chk("single.grant_one_cycle", 32'(FireGrant), 32'd0);
    ticks(44);
    chk("single.y44", 32'(LaserY), 32'd23);
    chk("single.active44", 32'(LaserActive), 32'd1);
    ticks(1);
    chk("single.active45", 32'(LaserActive), 32'd0);
    chk("single.y45", 32'(LaserY), 32'd23);
    ticks(3);
    chk("single.busy_cool3", 32'(Busy), 32'd1);
    ticks(1);
    chk("single.busy_cool4", 32'(Busy), 32'd0);

    // Round-robin ordering
    do_reset('0);
    fire(5'b01010);
    chk("rr.first", 32'(FireGrant), 32'b00010);
    wait_grant("rr.second", 5'b01000);
    cyc(1'b0, 5'b01001, 1'b0);
    wait_grant("rr.after3_lane0", 5'b00001);
    wait_grant("rr.after0_lane3", 5'b01000);

    // Early kill by HitAck together with FrameTick
    do_reset('0);
    fire(5'b00100);
    ticks(3);
    chk("kill.y_before", 32'(LaserY), 32'd351);
    cyc(1'b1, '0, 1'b1);
    chk("kill.y_held", 32'(LaserY), 32'd351);
    chk("kill.inactive", 32'(LaserActive), 32'd0);
    ticks(3);
    chk("kill.busy3", 32'(Busy), 32'd1);
    ticks(1);
    chk("kill.busy4", 32'(Busy), 32'd0);

    // Repeated edges while busy collapse into one request
    do_reset('0);
    fire(5'b00100);
    for (int p = 0; p < 3; p++) begin
      cyc(1'b1, 5'b10000, 1'b0);
      cyc(1'b1, '0, 1'b0);
    end
    wait_grant("busyreq.grant", 5'b10000);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, '0, 1'b0);
      if (FireGrant != '0) extra++;
    end
    chk("busyreq.single", 32'(extra), 32'd0);

    // Edge on lane 0 in the very cycle lane 0 is granted
    do_reset('0);
    fire(5'b00010);
    fire(5'b00001);
    ticks(45);
    chk("collide.cool", 32'(LaserActive), 32'd0);
    ticks(4);
    chk("collide.idle", 32'(Busy), 32'd0);
    cyc(1'b0, 5'b00001, 1'b0);
    chk("collide.grant", 32'(FireGrant), 32'b00001);
    cyc(1'b0, '0, 1'b0);
    wait_grant("collide.refire", 5'b00001);

    // Asynchronous reset mid-flight discards pending requests
    do_reset('0);
    fire(5'b00100);
    cyc(1'b1, 5'b10010, 1'b0);
    cyc(1'b0, '0, 1'b0);
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst.grant", 32'(FireGrant), 32'd0);
    chk("midrst.active", 32'(LaserActive), 32'd0);
    chk("midrst.lane", 32'(LaserLane), 32'd0);
    chk("midrst.x", 32'(LaserX), 32'd208);
    chk("midrst.y", 32'(LaserY), 32'd375);
    chk("midrst.busy", 32'(Busy), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, '0, 1'b0);
      if (FireGrant != '0) extra++;
    end
    chk("midrst.no_fire", 32'(extra), 32'd0);

    // Level already high at reset release counts as an edge
    do_reset(5'b00001);
    cyc(1'b0, 5'b00001, 1'b0);
    cyc(1'b0, 5'b00001, 1'b0);
    chk("lvlrst.grant", 32'(FireGrant), 32'b00001);

    // Randomized traffic against the model
    do_reset('0);
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] r;
      for (int k = 0; k < 5; k++) r[k] = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 2) == 0, r, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
